// File: rtl/fp16_pkg.sv
// Shared fp16 number conventions for the divider and the registered multiplier:
// field widths, special encodings, operand classes and divider FSM states.
package fp16_pkg;

   localparam int FP16_EXP_W = 5;
   localparam int FP16_MAN_W = 10;
   localparam int FP16_BIAS  = 15;

   localparam logic [15:0] FP16_QNAN    = 16'h7E00;
   localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

   // Operand class; subnormals are folded into ZERO (flush-to-zero).
   typedef enum logic [1:0] {
      CLS_ZERO   = 2'd0,
      CLS_NORMAL = 2'd1,
      CLS_INF    = 2'd2,
      CLS_NAN    = 2'd3
   } cls_e;

   // Divider sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_NORM = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Classify an fp16 operand from its exponent and stored mantissa.
   function automatic cls_e fp16_classify(input logic [4:0] exp_f, input logic [9:0] man_f);
      cls_e c;
      if (exp_f == 5'd0)
         c = CLS_ZERO;
      else if (exp_f == FP16_EXP_MAX)
         c = (man_f == 10'd0) ? CLS_INF : CLS_NAN;
      else
         c = CLS_NORMAL;
      return c;
   endfunction

endpackage

// File: rtl/fp16_mant_div_step.sv
// One restoring-division step on the 11-bit significands: compare, conditionally
// subtract, then shift the partial remainder left for the next quotient bit.
module fp16_mant_div_step (
   input  logic [11:0] rem,
   input  logic [10:0] mb,
   output logic        qbit,
   output logic [11:0] next_rem
);

   logic [11:0] diff;

   // Remainder stays below 2*mb, so the shifted value always fits in 12 bits.
   always_comb begin
      qbit     = (rem >= {1'b0, mb});
      diff     = qbit ? (rem - {1'b0, mb}) : rem;
      next_rem = diff << 1;
   end

endmodule

// File: rtl/fp16_divider.sv
// Sequential fp16 divider: out = A / B, one quotient bit per clock using a
// restoring mantissa divider. Truncating rounding, subnormals flushed to zero.
// Handshake: a start seen while busy=0 (IDLE or DONE) is accepted on that edge;
// busy stays high until the result edge, where done pulses for one cycle and
// out is updated; out then holds until the next done. Start is ignored while busy.
module fp16_divider
   import fp16_pkg::*;
#(
   parameter int EXP_W = FP16_EXP_W,
   parameter int MAN_W = FP16_MAN_W,
   parameter int BIAS  = FP16_BIAS
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        busy,
   output logic        done,
   output logic [15:0] out,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
   localparam logic [1:0] S_DIV  = 2'(ST_DIV);
   localparam logic [1:0] S_NORM = 2'(ST_NORM);
   localparam logic [1:0] S_DONE = 2'(ST_DONE);

   logic [1:0]       state;
   logic [3:0]       cnt;
   logic             sign;
   logic [EXP_W-1:0] ea;
   logic [EXP_W-1:0] eb;
   logic [MAN_W:0]   mb;
   logic [MAN_W+1:0] rem;
   logic [MAN_W+1:0] q;
   cls_e             cls_a;
   cls_e             cls_b;

   logic             step_qbit;
   logic [MAN_W+1:0] step_rem;

   logic [6:0]       e_val;
   logic [MAN_W-1:0] mant;
   logic [15:0]      res;

   assign dbg_state = state;

   fp16_mant_div_step u_step (
      .rem      (rem),
      .mb       (mb),
      .qbit     (step_qbit),
      .next_rem (step_rem)
   );

   // Normalise the quotient, apply range limits, then let special operand
   // classes override the arithmetic result.
   always_comb begin
      e_val = 7'(ea) - 7'(eb) + 7'(BIAS) - (q[MAN_W+1] ? 7'd0 : 7'd1);
      mant  = q[MAN_W+1] ? q[MAN_W:1] : q[MAN_W-1:0];
      res   = {sign, e_val[EXP_W-1:0], mant};
      if (e_val[6] || (e_val == 7'd0))
         res = {sign, 15'h0000};
      else if (e_val >= 7'd31)
         res = {sign, FP16_EXP_MAX, 10'h000};

      if ((cls_a == CLS_NAN) || (cls_b == CLS_NAN) ||
          ((cls_a == CLS_ZERO) && (cls_b == CLS_ZERO)) ||
          ((cls_a == CLS_INF)  && (cls_b == CLS_INF)))
         res = FP16_QNAN;
      else if ((cls_b == CLS_ZERO) || (cls_a == CLS_INF))
         res = {sign, FP16_EXP_MAX, 10'h000};
      else if ((cls_a == CLS_ZERO) || (cls_b == CLS_INF))
         res = {sign, 15'h0000};
   end

   // Control FSM, iteration counter, datapath capture and the output register.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         sign  <= 1'b0;
         ea    <= '0;
         eb    <= '0;
         mb    <= '0;
         rem   <= '0;
         q     <= '0;
         cls_a <= CLS_ZERO;
         cls_b <= CLS_ZERO;
         busy  <= 1'b0;
         done  <= 1'b0;
         out   <= 16'h0000;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  sign  <= A[15] ^ B[15];
                  ea    <= A[14:10];
                  eb    <= B[14:10];
                  rem   <= {1'b0, 1'b1, A[9:0]};
                  mb    <= {1'b1, B[9:0]};
                  cls_a <= fp16_classify(A[14:10], A[9:0]);
                  cls_b <= fp16_classify(B[14:10], B[9:0]);
                  q     <= '0;
                  cnt   <= 4'd11;
                  busy  <= 1'b1;
                  state <= S_DIV;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_DIV: begin
               q[cnt] <= step_qbit;
               rem    <= step_rem;
               if (cnt == 4'd0)
                  state <= S_NORM;
               else
                  cnt <= cnt - 4'd1;
            end
            S_NORM: begin
               out   <= res;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_divider.sv
// Self-checking bench for fp16_divider: directed scenarios plus random operands
// checked against an integer reference model through an expected-result queue.
module tb_fp16_divider;

   logic        CLK = 1'b0;
   logic        RESETn = 1'b1;
   logic        start = 1'b0;
   logic [15:0] A = 16'h0000;
   logic [15:0] B = 16'h0000;
   logic        busy;
   logic        done;
   logic [15:0] out;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];

   // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
   always #5 CLK = ~CLK;

   fp16_divider dut (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .start     (start),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .done      (done),
      .out       (out),
      .dbg_state (dbg_state)
   );

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "time limit");
   end

   // Independent reference: integer long division of the significands.
   function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
      logic s;
      int ea, eb, ma, mb, q, e, mant;
      logic az, ai, an, bz, bi, bn;
      s  = a[15] ^ b[15];
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      az = (ea == 0);
      ai = (ea == 31) && (a[9:0] == 10'd0);
      an = (ea == 31) && (a[9:0] != 10'd0);
      bz = (eb == 0);
      bi = (eb == 31) && (b[9:0] == 10'd0);
      bn = (eb == 31) && (b[9:0] != 10'd0);
      if (an || bn || (az && bz) || (ai && bi)) return 16'h7E00;
      if (bz || ai) return {s, 15'h7C00};
      if (az || bi) return {s, 15'h0000};
      ma = 1024 + int'(a[9:0]);
      mb = 1024 + int'(b[9:0]);
      q  = (ma * 2048) / mb;
      e  = ea - eb + 15;
      if (q >= 2048) begin
         mant = (q >> 1) & 1023;
      end else begin
         mant = q & 1023;
         e = e - 1;
      end
      if (e >= 31) return {s, 15'h7C00};
      if (e <= 0) return {s, 15'h0000};
      return {s, e[4:0], mant[9:0]};
   endfunction

   // Driver: called at a negedge; holds start across exactly one rising edge.
   task automatic drive_op(input logic [15:0] a, input logic [15:0] b);
      A = a;
      B = b;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   // Wait (bounded) for done; report latency in negedges, busy cycles seen,
   // the DUT result and the scoreboard's expected value.
   task automatic wait_done(output logic got, output int lat, output int busy_cyc,
                            output logic [15:0] res, output logic [15:0] expv);
      got = 1'b0;
      lat = 0;
      busy_cyc = 0;
      res = 16'h0000;
      expv = 16'hxxxx;
      while (!done && lat < 40) begin
         if (busy) busy_cyc++;
         @(negedge CLK);
         lat++;
      end
      if (done) begin
         got = 1'b1;
         res = out;
      end
      if (exp_q.size() > 0) expv = exp_q.pop_front();
   endtask

   task automatic test_reset();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++;
      if (out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", out); end
      checks++;
      if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      RESETn = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: busy=%b done=%b want 0/0", busy, done);
      end
   endtask

   task automatic test_basic();
      logic got; int lat, bc; logic [15:0] res, expv;
      exp_q.push_back(16'h4000);
      drive_op(16'h4000, 16'h3C00);
      wait_done(got, lat, bc, res, expv);
      checks++;
      if (!got) begin errors++; $display("FAIL basic_done: no done within %0d cycles", lat); end
      checks++;
      if (lat !== 13) begin errors++; $display("FAIL basic_latency: got %0d want 13", lat); end
      checks++;
      if (bc !== 13) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 13", bc); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
      checks++;
      if (res !== expv) begin errors++; $display("FAIL basic_result: got %h want %h", res, expv); end
      @(negedge CLK);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: done still %b", done); end
   endtask

   task automatic test_back_to_back();
      logic got; int lat, bc; logic [15:0] res, expv;
      exp_q.push_back(16'h3E00);
      drive_op(16'h4200, 16'h4000);
      wait_done(got, lat, bc, res, expv);
      checks++;
      if (!got || res !== expv) begin
         errors++; $display("FAIL b2b_first: done=%b got %h want %h", got, res, expv);
      end
      // Issue the next operation while done is high.
      exp_q.push_back(16'h3555);
      drive_op(16'h3C00, 16'h4200);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b want 1", busy); end
      wait_done(got, lat, bc, res, expv);
      checks++;
      if (lat !== 13) begin errors++; $display("FAIL b2b_latency: got %0d want 13", lat); end
      checks++;
      if (res !== expv) begin errors++; $display("FAIL b2b_second: got %h want %h", res, expv); end
      @(negedge CLK);
   endtask

   task automatic test_specials();
      logic [15:0] ta[7] = '{16'hBC00, 16'h0000, 16'h7C00, 16'h4000, 16'h7E01, 16'h7BFF, 16'h0400};
      logic [15:0] tb[7] = '{16'h0000, 16'h0000, 16'h4000, 16'hFC00, 16'h3C00, 16'h0400, 16'h7BFF};
      logic [15:0] te[7] = '{16'hFC00, 16'h7E00, 16'h7C00, 16'h8000, 16'h7E00, 16'h7C00, 16'h0000};
      logic got; int lat, bc; logic [15:0] res, expv;
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(te[i]);
         drive_op(ta[i], tb[i]);
         wait_done(got, lat, bc, res, expv);
         checks++;
         if (!got || lat !== 13 || res !== expv) begin
            errors++;
            $display("FAIL special_%0d: %h/%h done=%b lat=%0d got %h want %h",
                     i, ta[i], tb[i], got, lat, res, expv);
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_random();
      logic got; int lat, bc; logic [15:0] res, expv, a, b;
      for (int i = 0; i < 16; i++) begin
         a = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 10'($urandom_range(0, 1023))};
         b = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 10'($urandom_range(0, 1023))};
         exp_q.push_back(ref_div(a, b));
         drive_op(a, b);
         wait_done(got, lat, bc, res, expv);
         checks++;
         if (!got || res !== expv) begin
            errors++; $display("FAIL random_%0d: %h/%h done=%b got %h want %h", i, a, b, got, res, expv);
         end
      end
      @(negedge CLK);
   endtask

   task automatic test_ignore_busy();
      logic got; int lat, bc, extra; logic [15:0] res, expv;
      exp_q.push_back(16'h3E00);
      drive_op(16'h4200, 16'h4000);
      start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         A = 16'($urandom);
         B = 16'($urandom);
         @(negedge CLK);
      end
      start = 1'b0;
      wait_done(got, lat, bc, res, expv);
      checks++;
      if (!got || lat !== 3) begin
         errors++; $display("FAIL ignore_timing: done=%b remaining=%0d want 3", got, lat);
      end
      checks++;
      if (res !== expv) begin errors++; $display("FAIL ignore_result: got %h want %h", res, expv); end
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (done) extra++;
      end
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL ignore_extra_done: got %0d extra, want 0", extra); end
   endtask

   task automatic test_reset_mid();
      logic got; int lat, bc, extra; logic [15:0] res, expv;
      drive_op(16'h4000, 16'h3C00);
      repeat (5) @(negedge CLK);
      #2 RESETn = 1'b0;
      #1;
      checks++;
      if (out !== 16'h0000) begin errors++; $display("FAIL midreset_out: got %h want 0000", out); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
      checks++;
      if (dbg_state !== 2'd0) begin errors++; $display("FAIL midreset_state: got %0d want 0", dbg_state); end
      @(negedge CLK);
      RESETn = 1'b1;
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (done || busy) extra++;
      end
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL midreset_no_done: %0d busy/done cycles, want 0", extra); end
      exp_q.push_back(16'h3E00);
      drive_op(16'h4200, 16'h4000);
      wait_done(got, lat, bc, res, expv);
      checks++;
      if (!got || lat !== 13) begin errors++; $display("FAIL midreset_latency: done=%b got %0d want 13", got, lat); end
      checks++;
      if (res !== expv) begin errors++; $display("FAIL midreset_result: got %h want %h", res, expv); end
   endtask

   initial begin
      #1 RESETn = 1'b0;
      repeat (3) @(negedge CLK);
      test_reset();
      test_basic();
      test_back_to_back();
      test_specials();
      test_random();
      test_ignore_busy();
      test_reset_mid();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL scoreboard_drain: %0d expected results left", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
